// File: rtl/rf_arb_pkg.sv
// Shared constants, FSM encoding and counter helper for the register-file write arbiter.
package rf_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
    localparam int CNT_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wr_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid index after ptr_i, nothing while hold_i.
module rr_picker
    import rf_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    input  logic               hold_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o
);

    // Scan ptr+1, ptr+2, ... (mod NUM_REQ) and take the first valid requester.
    always_comb begin
        int   cand;
        logic found;
        logic hit;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        hit     = 1'b0;
        cand    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand  = (int'(ptr_i) + k) % NUM_REQ;
            hit   = !hold_i && !found && valid_i[cand[IDX_W-1:0]];
            grant_o[cand[IDX_W-1:0]] = grant_o[cand[IDX_W-1:0]] | hit;
            idx_o = hit ? cand[IDX_W-1:0] : idx_o;
            found = found | hit;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port; winner's write is registered.
// Define RF_ARB_STATS_EN to add per-requester saturating accept counters (grant_cnt).
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int DATA_W  = REG_DATA_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        hold,
    output logic                        rf_we,
    output logic [ADDR_W-1:0]           rf_waddr,
    output logic [DATA_W-1:0]           rf_wdata,
`ifdef RF_ARB_STATS_EN
    output logic [NUM_REQ*CNT_W-1:0]    grant_cnt,
`endif
    output logic [$clog2(NUM_REQ)-1:0]  grant_idx
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_REQ - 1);

    wr_state_e          state_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   gidx_q;
    logic [ADDR_W-1:0]  waddr_q;
    logic [DATA_W-1:0]  wdata_q;

    logic [NUM_REQ-1:0] grant_s;
    logic [IDX_W-1:0]   idx_s;
    logic               accept_s;
    logic [ADDR_W-1:0]  win_addr_s;
    logic [DATA_W-1:0]  win_data_s;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .hold_i  (hold),
        .grant_o (grant_s),
        .idx_o   (idx_s)
    );

    assign req_ready = grant_s;
    assign accept_s  = |grant_s;

    // One-hot mux of the winner's address and data.
    always_comb begin
        win_addr_s = '0;
        win_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_addr_s = win_addr_s | ({ADDR_W{grant_s[i]}} & req_addr[i*ADDR_W +: ADDR_W]);
            win_data_s = win_data_s | ({DATA_W{grant_s[i]}} & req_data[i*DATA_W +: DATA_W]);
        end
    end

    // Write FSM with pointer and output registers; r0 writes are consumed but never raise rf_we.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= PTR_RST;
            gidx_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            if (accept_s) begin
                ptr_q   <= idx_s;
                gidx_q  <= idx_s;
                waddr_q <= win_addr_s;
                wdata_q <= win_data_s;
            end else begin
                ptr_q   <= ptr_q;
                gidx_q  <= gidx_q;
                waddr_q <= waddr_q;
                wdata_q <= wdata_q;
            end
            case (state_q)
                IDLE, WRITE: state_q <= (accept_s && (win_addr_s != ADDR_W'(ZERO_REG))) ? WRITE : IDLE;
                default:     state_q <= IDLE;
            endcase
        end
    end

    assign rf_we     = (state_q == WRITE);
    assign rf_waddr  = waddr_q;
    assign rf_wdata  = wdata_q;
    assign grant_idx = gidx_q;

`ifdef RF_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        // Saturating accept counter for requester g.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q[g] <= '0;
            end else if (grant_s[g]) begin
                cnt_q[g] <= sat_inc(cnt_q[g]);
            end else begin
                cnt_q[g] <= cnt_q[g];
            end
        end
        assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: behavioural model plus directed scenarios.
module tb_rf_write_arbiter;

    localparam int N  = 2;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            hold;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [DW-1:0]   rf_wdata;
    logic            grant_idx;
`ifdef RF_ARB_STATS_EN
    logic [N*16-1:0] grant_cnt;
`endif

    rf_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .hold      (hold),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
`ifdef RF_ARB_STATS_EN
        .grant_cnt (grant_cnt),
`endif
        .grant_idx (grant_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] rf [32] = '{default: 32'h0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin rule: first valid requester after the last winner, none while held.
    function automatic int winner(input logic [N-1:0] v, input int last, input logic h);
        int c;
        if (h) return -1;
        for (int k = 1; k <= N; k++) begin
            c = (last + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    int            m_last;
    int            m_w;
    logic [N-1:0]  m_ready;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            m_gidx;
    int            m_cnt [N];

    always_comb begin
        m_w     = winner(req_valid, m_last, hold);
        m_ready = (m_w >= 0) ? (2'b01 << m_w) : 2'b00;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last <= N - 1;
            m_we   <= 1'b0;
            m_addr <= '0;
            m_data <= '0;
            m_gidx <= 0;
            for (int i = 0; i < N; i++) m_cnt[i] <= 0;
        end else if (m_w >= 0) begin
            m_last <= m_w;
            m_gidx <= m_w;
            m_addr <= req_addr[m_w*AW +: AW];
            m_data <= req_data[m_w*DW +: DW];
            m_we   <= (req_addr[m_w*AW +: AW] != 5'd0);
            m_cnt[m_w] <= (m_cnt[m_w] == 65535) ? 65535 : m_cnt[m_w] + 1;
        end else begin
            m_we <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready", 64'(req_ready), 64'(m_ready));
            chk("rf_we", 64'(rf_we), 64'(m_we));
            chk("rf_waddr", 64'(rf_waddr), 64'(m_addr));
            chk("rf_wdata", 64'(rf_wdata), 64'(m_data));
            chk("grant_idx", 64'(grant_idx), 64'(m_gidx));
        end
    end

    // Register file stand-in committing on the falling edge.
    always @(negedge clk) begin
        if (rst_n && rf_we) rf[rf_waddr] <= rf_wdata;
    end

    task automatic cyc(input logic [N-1:0] v, input logic h);
        @(posedge clk);
        #1;
        req_valid = v;
        hold      = h;
        #2;
    endtask

    initial begin
        int we_cnt;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        hold      = 1'b0;
        req_addr  = {5'd4, 5'd3};
        req_data  = {32'hBBBB_0002, 32'hAAAA_0001};
        repeat (2) @(posedge clk);
        #3;
        chk("rst_we", 64'(rf_we), 64'd0);
        chk("rst_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_wdata", 64'(rf_wdata), 64'd0);
        chk("rst_gidx", 64'(grant_idx), 64'd0);

        // Test 1: first grant goes to requester 0 after reset
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = 2'b11;
        #2;
        chk("t1_ready0", 64'(req_ready), 64'h1);
        cyc(2'b10, 1'b0);
        chk("t1_ready1", 64'(req_ready), 64'h2);
        chk("t1_we0", 64'(rf_we), 64'd1);
        chk("t1_addr0", 64'(rf_waddr), 64'd3);
        chk("t1_data0", 64'(rf_wdata), 64'hAAAA_0001);
        cyc(2'b00, 1'b0);
        chk("t1_we1", 64'(rf_we), 64'd1);
        chk("t1_addr1", 64'(rf_waddr), 64'd4);
        chk("t1_data1", 64'(rf_wdata), 64'hBBBB_0002);
        cyc(2'b00, 1'b0);
        chk("t1_rf3", 64'(rf[3]), 64'hAAAA_0001);
        chk("t1_rf4", 64'(rf[4]), 64'hBBBB_0002);
        chk("t1_idle_we", 64'(rf_we), 64'd0);

        // Test 2: continuous contention alternates and sustains one write per cycle
        req_addr = {5'd6, 5'd5};
        req_data = {32'h6666_0006, 32'h5555_0005};
        we_cnt   = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(2'b11, 1'b0);
            chk("t2_ready", 64'(req_ready), (i % 2 == 0) ? 64'h1 : 64'h2);
            if (i > 0) we_cnt += int'(rf_we);
        end
        cyc(2'b00, 1'b0);
        we_cnt += int'(rf_we);
        chk("t2_we_run", 64'(we_cnt), 64'd6);
        cyc(2'b00, 1'b0);
        chk("t2_rf5", 64'(rf[5]), 64'h5555_0005);
        chk("t2_rf6", 64'(rf[6]), 64'h6666_0006);

        // Test 3: r0 write is accepted but suppressed
        req_addr[4:0]  = 5'd0;
        req_data[31:0] = 32'hFFFF_FFFF;
        cyc(2'b01, 1'b0);
        chk("t3_ready", 64'(req_ready), 64'h1);
        cyc(2'b00, 1'b0);
        chk("t3_we", 64'(rf_we), 64'd0);
        chk("t3_gidx", 64'(grant_idx), 64'd0);
        cyc(2'b00, 1'b0);
        chk("t3_rf0", 64'(rf[0]), 64'd0);

        // Test 4: hold blocks grants, then arbitration resumes after requester 0
        req_addr = {5'd9, 5'd8};
        req_data = {32'h9999_0009, 32'h8888_0008};
        for (int i = 0; i < 3; i++) begin
            cyc(2'b11, 1'b1);
            chk("t4_hold_ready", 64'(req_ready), 64'h0);
            chk("t4_hold_we", 64'(rf_we), 64'd0);
        end
        cyc(2'b11, 1'b0);
        chk("t4_resume", 64'(req_ready), 64'h2);
        cyc(2'b01, 1'b0);
        chk("t4_ready0", 64'(req_ready), 64'h1);
        chk("t4_addr9", 64'(rf_waddr), 64'd9);
        cyc(2'b00, 1'b0);
        chk("t4_addr8", 64'(rf_waddr), 64'd8);

        // Test 5: reset between accept and commit loses the write
        req_addr[4:0]  = 5'd7;
        req_data[31:0] = 32'hDEAD_BEEF;
        cyc(2'b01, 1'b0);
        chk("t5_ready", 64'(req_ready), 64'h1);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        chk("t5_we_up", 64'(rf_we), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_we_drop", 64'(rf_we), 64'd0);
        chk("t5_waddr", 64'(rf_waddr), 64'd0);
        @(negedge clk);
        #1;
        chk("t5_rf7", 64'(rf[7]), 64'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = 2'b11;
        #2;
        chk("t5_ptr_rst", 64'(req_ready), 64'h1);
        cyc(2'b00, 1'b0);

`ifdef RF_ARB_STATS_EN
        // Test 6: requester 1 counter saturates, requester 0 counter untouched
        req_addr = {5'd10, 5'd11};
        cyc(2'b10, 1'b0);
        repeat (70000) @(posedge clk);
        #1;
        req_valid = 2'b00;
        cyc(2'b00, 1'b0);
        chk("t6_cnt1_sat", 64'(grant_cnt[31:16]), 64'hFFFF);
        chk("t6_cnt0_lit", 64'(grant_cnt[15:0]), 64'd1);
        chk("t6_cnt0_model", 64'(grant_cnt[15:0]), 64'(m_cnt[0]));
        chk("t6_cnt1_model", 64'(grant_cnt[31:16]), 64'(m_cnt[1]));
`endif

        cyc(2'b00, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
